keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scanner_frame_debouncer.sv | 53 +++++
 rtl/keypad_scanner.sv | 124 ++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS   = 4;
    localparam int NUM_ROWS   = 4;
    localparam int KEY_CODE_W = 4;
    localparam int NUM_KEYS   = NUM_COLS * NUM_ROWS;

    // Active-low one-hot column drive, indexed by column number.
    localparam logic [NUM_COLS-1:0][NUM_COLS-1:0] COL_DRIVE =
        {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Key index = col*4 + row.
    function automatic logic [KEY_CODE_W-1:0] key_index(input logic [1:0] col,
                                                        input logic [1:0] row);
        return {col, row};
    endfunction

    function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] m);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (m[i]) idx = KEY_CODE_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_frame_debouncer.sv
// Frame-level debouncer: the stable map follows the raw frame once it has
// been seen DEBOUNCE_FRAMES times in a row.
module frame_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] i_frame,
    input  logic                i_frame_stb,
    output logic [NUM_KEYS-1:0] o_map,
    output logic [NUM_KEYS-1:0] o_next_map,
    output logic                o_update
);

    localparam logic [7:0] DF = 8'(DEBOUNCE_FRAMES);

    logic [NUM_KEYS-1:0] r_prev;
    logic [NUM_KEYS-1:0] r_map;
    logic [7:0]          r_match;
    logic                r_load;
    logic [7:0]          w_match_nxt;

    always_comb begin
        w_match_nxt = 8'd1;
        if (i_frame == r_prev)
            w_match_nxt = (r_match == DF) ? r_match : r_match + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= '0;
            r_match <= '0;
            r_load  <= 1'b0;
            r_map   <= '0;
        end else begin
            r_load <= i_frame_stb && (w_match_nxt == DF);
            if (i_frame_stb) begin
                r_prev  <= i_frame;
                r_match <= w_match_nxt;
            end
            // r_prev already holds the qualifying frame one cycle after the strobe.
            if (r_load)
                r_map <= r_prev;
        end
    end

    assign o_map      = r_map;
    assign o_next_map = r_prev;
    assign o_update   = r_load;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame debounce and press-event queue.
// Optional autorepeat enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIVIDER    = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [NUM_COLS-1:0]   io_col,
    input  logic [NUM_ROWS-1:0]   io_row,
    output logic [NUM_KEYS-1:0]   key_map,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_down
);

    logic [NUM_ROWS-1:0]   r_row_s1, r_row_s2;
    logic [15:0]           r_dwell;
    logic [1:0]            r_col;
    logic [NUM_KEYS-1:0]   r_raw;
    logic [NUM_KEYS-1:0]   r_pend;
    logic                  r_valid;
    logic [KEY_CODE_W-1:0] r_code;

    logic                  w_last, w_frame_stb, w_update;
    logic [NUM_KEYS-1:0]   w_raw_nxt, w_next_map, w_rise, w_take, w_rep, w_pend_nxt;

    assign w_last      = (r_dwell == 16'(SCAN_DIVIDER - 1));
    assign w_frame_stb = w_last && (r_col == 2'd3);

    // Current column's rows merged into the raw frame; on column 3 this is the full frame.
    always_comb begin
        w_raw_nxt = r_raw;
        for (int r = 0; r < NUM_ROWS; r++)
            w_raw_nxt[key_index(r_col, 2'(r))] = ~r_row_s2[r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
            r_dwell  <= '0;
            r_col    <= '0;
            r_raw    <= '0;
        end else begin
            r_row_s1 <= io_row;
            r_row_s2 <= r_row_s1;
            if (w_last) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_raw   <= w_raw_nxt;
            end else begin
                r_dwell <= r_dwell + 16'd1;
            end
        end
    end

    frame_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
        .clk        (clk),
        .rst        (rst),
        .i_frame    (w_raw_nxt),
        .i_frame_stb(w_frame_stb),
        .o_map      (key_map),
        .o_next_map (w_next_map),
        .o_update   (w_update)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    logic        r_stb_d;
    logic [15:0] r_rep;
    logic        w_onehot, w_map_chg;

    assign w_onehot  = (key_map != '0) && ((key_map & (key_map - 1'b1)) == '0);
    assign w_map_chg = w_update && (w_next_map != key_map);
    // Counted on the delayed strobe so repeats land in the same phase as the press event.
    assign w_rep = (r_stb_d && !w_map_chg && w_onehot && r_rep == 16'(REPEAT_FRAMES - 1))
                   ? key_map : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb_d <= 1'b0;
            r_rep   <= '0;
        end else begin
            r_stb_d <= w_frame_stb;
            if (w_map_chg || (r_stb_d && !w_onehot))
                r_rep <= '0;
            else if (r_stb_d)
                r_rep <= (r_rep == 16'(REPEAT_FRAMES - 1)) ? 16'd0 : r_rep + 16'd1;
        end
    end
`else
    logic [15:0] w_unused_rep;
    assign w_unused_rep = 16'(REPEAT_FRAMES);
    assign w_rep        = '0;
`endif

    always_comb begin
        w_rise     = w_update ? (w_next_map & ~key_map) : '0;
        w_take     = (r_pend != '0) ? (NUM_KEYS'(1) << lowest_set(r_pend)) : '0;
        w_pend_nxt = (r_pend & ~w_take) | w_rise | w_rep;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_code  <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_valid <= (r_pend != '0);
            if (r_pend != '0)
                r_code <= lowest_set(r_pend);
        end
    end

    assign io_col    = COL_DRIVE[r_col];
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = |key_map;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: matrix model plus event scoreboard.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int RF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  io_col, io_row;
    logic [15:0] key_map;
    logic [3:0]  key_code;
    logic        key_valid, key_down;

    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    keypad_scanner #(.SCAN_DIVIDER(SD), .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(RF)) dut (
        .clk(clk), .rst(rst), .io_col(io_col), .io_row(io_row),
        .key_map(key_map), .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        io_row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!io_col[c] && keys[c*4+r]) io_row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got code %0d, expected none", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp)
                    $display("FAIL event_code: got %0d, expected %0d", key_code, mon_exp);
                else
                    passed++;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] k);
        rst  = 1'b1;
        keys = k;
        wait_cycles(3);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        wait_cycles(2);
        total++;
        if ({io_col, key_map, key_code, key_valid, key_down} !== {4'b1110, 16'h0, 4'h0, 2'b00})
            $display("FAIL reset_state: got col=%b map=%h code=%0d v=%b d=%b", io_col, key_map,
                     key_code, key_valid, key_down);
        else passed++;
    endtask

    task automatic test_idle_scan();
        logic [3:0] e;
        do_reset(16'h0);
        wait_cycles(1);
        for (int k = 0; k < 5; k++) begin
            e = ~(4'b0001 << (k % 4));
            total++;
            if (io_col !== e) $display("FAIL col_step%0d: got %b, expected %b", k, io_col, e);
            else passed++;
            wait_cycles(SD);
        end
        wait_cycles(64);
        total++;
        if (key_map !== 16'h0 || exp_q.size() != 0)
            $display("FAIL idle_map: got %h, expected 0000", key_map);
        else passed++;
    endtask

    task automatic test_single_key();
        do_reset(16'h0040);
        exp_q.push_back(4'd6);
        wait_cycles(45);
        total++;
        if (key_map !== 16'h0) $display("FAIL single_early: got %h, expected 0000", key_map);
        else passed++;
        wait_cycles(5);
        total++;
        if (key_map !== 16'h0040 || key_down !== 1'b1)
            $display("FAIL single_map: got %h down=%b, expected 0040 down=1", key_map, key_down);
        else passed++;
        wait_cycles(30);
        total++;
        if (exp_q.size() != 0 || key_code !== 4'd6 || key_valid !== 1'b0)
            $display("FAIL single_event: pending=%0d code=%0d v=%b, expected 0 6 0",
                     exp_q.size(), key_code, key_valid);
        else passed++;
        keys = 16'h0;
        wait_cycles(64);
        total++;
        if (key_map !== 16'h0 || key_down !== 1'b0 || key_code !== 4'd6)
            $display("FAIL release: got map=%h code=%0d, expected 0000 6", key_map, key_code);
        else passed++;
    endtask

    task automatic test_bounce();
        do_reset(16'h0);
        for (int f = 0; f < 10; f++) begin
            keys = (f % 2 == 0) ? 16'h0020 : 16'h0000;
            wait_cycles(16);
        end
        keys = 16'h0020;
        exp_q.push_back(4'd5);
        wait_cycles(32);
        total++;
        if (key_map !== 16'h0 || exp_q.size() != 1)
            $display("FAIL bounce_early: got map=%h pending=%0d, expected 0000 1", key_map, exp_q.size());
        else passed++;
        wait_cycles(19);
        total++;
        if (key_map !== 16'h0020 || exp_q.size() != 0)
            $display("FAIL bounce_settle: got map=%h pending=%0d, expected 0020 0", key_map, exp_q.size());
        else passed++;
        wait_cycles(48);
        total++;
        if (key_map !== 16'h0020) $display("FAIL bounce_hold: got %h, expected 0020", key_map);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int t;
        bit ok;
        do_reset(16'h1008);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd12);
        wait_valid(t, ok);
        total++;
        if (!ok) $display("FAIL b2b_first: got timeout, expected key_valid");
        else passed++;
        wait_cycles(1);
        total++;
        if (key_valid !== 1'b1) $display("FAIL b2b_second: got v=%b, expected 1", key_valid);
        else passed++;
        wait_cycles(1);
        total++;
        if (key_valid !== 1'b0 || key_code !== 4'd12 || key_map !== 16'h1008)
            $display("FAIL b2b_hold: got v=%b code=%0d map=%h, expected 0 12 1008",
                     key_valid, key_code, key_map);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset(16'h0200);
        exp_q.push_back(4'd9);
        wait_cycles(59);
        total++;
        if (key_map !== 16'h0200 || exp_q.size() != 0 || io_col !== 4'b1011)
            $display("FAIL pre_reset: got map=%h col=%b, expected 0200 1011", key_map, io_col);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({io_col, key_map, key_code, key_valid, key_down} !== {4'b1110, 16'h0, 4'h0, 2'b00})
            $display("FAIL mid_reset: got col=%b map=%h code=%0d v=%b d=%b", io_col, key_map,
                     key_code, key_valid, key_down);
        else passed++;
        wait_cycles(3);
        rst = 1'b0;
        exp_q.push_back(4'd9);
        wait_cycles(48);
        total++;
        if (key_map !== 16'h0 || exp_q.size() != 1)
            $display("FAIL rst_refill: got map=%h pending=%0d, expected 0000 1", key_map, exp_q.size());
        else passed++;
        wait_cycles(3);
        total++;
        if (key_map !== 16'h0200 || exp_q.size() != 0)
            $display("FAIL rst_event: got map=%h pending=%0d, expected 0200 0", key_map, exp_q.size());
        else passed++;
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int t[3];
        bit ok;
        do_reset(16'h0001);
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(4'd0);
            wait_valid(t[n], ok);
            total++;
            if (!ok) $display("FAIL repeat_wait%0d: got timeout, expected event", n);
            else passed++;
        end
        total++;
        if (t[1] - t[0] != 80 || t[2] - t[1] != 80)
            $display("FAIL repeat_period: got %0d,%0d, expected 80,80", t[1] - t[0], t[2] - t[1]);
        else passed++;
        keys = 16'h0003;
        exp_q.push_back(4'd1);
        wait_cycles(250);
        total++;
        if (exp_q.size() != 0 || key_map !== 16'h0003)
            $display("FAIL repeat_stop: got map=%h pending=%0d, expected 0003 0", key_map, exp_q.size());
        else passed++;
    endtask
`else
    task automatic test_autorepeat();
        do_reset(16'h0001);
        exp_q.push_back(4'd0);
        wait_cycles(250);
        total++;
        if (exp_q.size() != 0 || key_map !== 16'h0001)
            $display("FAIL no_repeat: got map=%h pending=%0d, expected 0001 0", key_map, exp_q.size());
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        test_autorepeat();
        wait_cycles(4);
        total++;
        if (exp_q.size() != 0) $display("FAIL leftover_events: got %0d, expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
